fifo_two_depth_serializer_rd: RTL and testbench

//  Read-side consumer for the 2-deep FIFO. Pops FIFO_DATA_WIDTH words through the FIFO's

---
 rtl/fifo_two_depth_serializer_rd_pkg.sv | 11 +
 rtl/fifo_two_depth_serializer_rd.sv | 92 +++++++++
 tb/tb_fifo_two_depth_serializer_rd.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_two_depth_serializer_rd_pkg.sv
// Shared definitions for the FIFO read-side serializer: FSM state encoding and counter width.
package fifo_two_depth_serializer_rd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/fifo_two_depth_serializer_rd.sv
// Pops words from the 2-deep FIFO and streams each as LSB-first narrow beats on valid/ready.
// Optional build macro FIFO_RD_PARITY_EN adds an even-parity output for each beat.
module fifo_two_depth_serializer_rd
  import fifo_two_depth_serializer_rd_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BEAT_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fifo_empty_i,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                       fifo_rden_o,
  output logic                       beat_valid_o,
  input  logic                       beat_ready_i,
  output logic [BEAT_WIDTH-1:0]      beat_data_o,
  output logic                       beat_last_o,
  output logic                       busy_o,
  output logic [WORD_CNT_W-1:0]      word_cnt_o
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                       beat_parity_o
`endif
);

  localparam int BEATS      = FIFO_DATA_WIDTH / BEAT_WIDTH;
  localparam int BEAT_CNT_W = $clog2(BEATS);

  if ((FIFO_DATA_WIDTH % BEAT_WIDTH) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("fifo_two_depth_serializer_rd: BEAT_WIDTH must divide FIFO_DATA_WIDTH into >= 2 beats");
  end

  state_t                   state, state_nxt;
  logic [FIFO_DATA_WIDTH-1:0] shift;
  logic [BEAT_CNT_W-1:0]    beat_cnt;
  logic [WORD_CNT_W-1:0]    word_cnt;
  logic                     last_beat;
  logic                     accept;
  logic                     load;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nxt    = state;
    last_beat    = (beat_cnt == BEAT_CNT_W'(BEATS - 1));
    beat_valid_o = (state == ST_SEND);
    beat_last_o  = beat_valid_o && last_beat;
    beat_data_o  = beat_valid_o ? shift[BEAT_WIDTH-1:0] : '0;
    accept       = beat_valid_o && beat_ready_i;
    // Reload on the last-beat handshake keeps words back-to-back with no idle cycle.
    load         = !fifo_empty_i && ((state == ST_IDLE) || (accept && last_beat));

    case (state)
      ST_IDLE: if (load) state_nxt = ST_SEND;
      ST_SEND: if (accept && last_beat) state_nxt = load ? ST_SEND : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fifo_rden_o = load;
  assign busy_o      = (state == ST_SEND);
  assign word_cnt_o  = word_cnt;

`ifdef FIFO_RD_PARITY_EN
  assign beat_parity_o = ^beat_data_o;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift    <= '0;
      beat_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (load) begin
        shift    <= fifo_rdata_i;
        beat_cnt <= '0;
      end else if (accept && !last_beat) begin
        shift    <= shift >> BEAT_WIDTH;
        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      end
      if (accept && last_beat) word_cnt <= word_cnt + WORD_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_two_depth_serializer_rd.sv
// Self-checking bench: behavioural 2-deep FIFO plus a beat-order reference model.
// Parity checks are active when FIFO_RD_PARITY_EN is defined.
module tb_fifo_two_depth_serializer_rd;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int BEATS = DW / BW;

  typedef struct {
    logic [BW-1:0] data;
    bit            last;
    int            push_cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [BW-1:0] beat_data;
  logic          beat_last;
  logic          busy;
  logic [15:0]   word_cnt;
`ifdef FIFO_RD_PARITY_EN
  logic          beat_parity;
`endif

  fifo_two_depth_serializer_rd #(.FIFO_DATA_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rden_o  (fifo_rden),
    .beat_valid_o (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_data_o  (beat_data),
    .beat_last_o  (beat_last),
    .busy_o       (busy),
    .word_cnt_o   (word_cnt)
`ifdef FIFO_RD_PARITY_EN
    ,
    .beat_parity_o(beat_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural 2-deep FIFO feeding the DUT.
  logic [DW-1:0] mem [2];
  logic          head;
  int            fifo_cnt;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  int            cyc = 0;
  beat_t         exp_q[$];

  assign fifo_empty = (fifo_cnt == 0);
  assign fifo_rdata = mem[head];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt <= 0;
      head     <= 1'b0;
    end else begin
      if (fifo_rden && fifo_cnt != 0) head <= ~head;
      if (push_req) begin
        mem[head ^ fifo_cnt[0]] <= push_data;
        for (int b = 0; b < BEATS; b++)
          exp_q.push_back('{data: push_data[b*BW +: BW], last: (b == BEATS - 1), push_cyc: cyc + 1});
      end
      fifo_cnt <= fifo_cnt + int'(push_req) - int'(fifo_rden && fifo_cnt != 0);
    end
  end

  // Reference: the next pending beat is offered once its word has sat in the FIFO for one edge.
  logic [15:0] exp_wcnt = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_wcnt = '0;
      check("rst_valid", {31'b0, beat_valid}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_wcnt", {16'b0, word_cnt}, 0);
    end else begin
      bit exp_valid;
      exp_valid = (exp_q.size() != 0) && (exp_q[0].push_cyc < cyc);
      check("valid", {31'b0, beat_valid}, {31'b0, exp_valid});
      check("busy", {31'b0, busy}, {31'b0, exp_valid});
      check("wcnt", {16'b0, word_cnt}, {16'b0, exp_wcnt});
      check("rden_empty", {31'b0, fifo_rden && fifo_empty}, 0);
      if (exp_valid) begin
        check("data", {24'b0, beat_data}, {24'b0, exp_q[0].data});
        check("last", {31'b0, beat_last}, {31'b0, exp_q[0].last});
      end else begin
        check("idle_data", {24'b0, beat_data}, 0);
      end
`ifdef FIFO_RD_PARITY_EN
      check("parity", {31'b0, beat_parity}, exp_valid ? {31'b0, ^exp_q[0].data} : 32'd0);
`endif
      if (exp_valid && beat_ready) begin
        if (exp_q[0].last) exp_wcnt = exp_wcnt + 16'd1;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit push, input logic [DW-1:0] w, input bit rdy);
    @(posedge clk);
    #2;
    push_req   = push && (fifo_cnt < 2);
    push_data  = w;
    beat_ready = rdy;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single word, ready held high.
    step(1, 32'hDDCCBBAA, 1);
    repeat (7) step(0, '0, 1);
    check("t1_wcnt", {16'b0, word_cnt}, 1);

    // Two words back-to-back.
    step(1, 32'h04030201, 1);
    step(1, 32'h08070605, 1);
    repeat (11) step(0, '0, 1);
    check("t2_wcnt", {16'b0, word_cnt}, 3);

    // Ready toggling.
    step(1, 32'h5A6B7C8D, 1);
    for (int i = 0; i < 14; i++) step(0, '0, (i % 2) == 1);
    check("t3_wcnt", {16'b0, word_cnt}, 4);

    // FIFO empty for 20 cycles.
    for (int i = 0; i < 20; i++) step(0, '0, 1'($urandom_range(0, 1)));

    // Reset after two beats have been accepted.
    step(1, 32'hA3A2A1A0, 1);
    step(0, '0, 1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, beat_valid}, 0);
    check("ar_busy", {31'b0, busy}, 0);
    check("ar_data", {24'b0, beat_data}, 0);
    check("ar_last", {31'b0, beat_last}, 0);
    check("ar_rden", {31'b0, fifo_rden}, 0);
    check("ar_wcnt", {16'b0, word_cnt}, 0);
    push_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step(1, 32'h44332211, 1);
    repeat (6) step(0, '0, 1);
    check("t5_wcnt", {16'b0, word_cnt}, 1);

    // Parity pattern word.
    step(1, 32'h00000701, 1);
    repeat (6) step(0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      step(($urandom % 2) == 0, $urandom, ($urandom % 4) != 0);

    // Drain.
    repeat (30) step(0, '0, 1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_fifo", fifo_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
